// File: rtl/alu_stream_pkg.sv
// alu_stream_pkg: shared types and widths for the ALU stream initiator.
// Holds FSM encodings and the buffered entry layout.
package alu_stream_pkg;

  localparam int OP_W    = 8;
  localparam int INSTR_W = 4;
  localparam int ENTRY_W = 2 * OP_W + INSTR_W;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SEND,
    GAPW,
    WAIT
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]    a;
    logic [OP_W-1:0]    b;
    logic [INSTR_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/alu_stream_tx_if.sv
// alu_stream_tx_if: operand stream toward the consumer
// and its result strobe back.
interface alu_stream_tx_if;
  import alu_stream_pkg::*;

  logic [OP_W-1:0]    A;
  logic [OP_W-1:0]    B;
  logic [INSTR_W-1:0] instruction;
  logic               data_valid;
  logic               last_data;
  logic [OP_W-1:0]    third_largest;
  logic               result_valid;

  modport master (
    output A, B, instruction,
    output data_valid, last_data,
    input  third_largest, result_valid
  );

  modport slave (
    input  A, B, instruction,
    input  data_valid, last_data,
    output third_largest, result_valid
  );

endinterface

// File: rtl/alu_stream_buf.sv
// alu_stream_buf: frame buffer of operand triples.
// Appends at the write pointer, random read by index.
module alu_stream_buf
  import alu_stream_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  entry_t        wr_data_i,
  input  logic          clr_i,
  input  logic [IW-1:0] rd_idx_i,
  output entry_t        rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  entry_t        mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic          wr;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign wr        = wr_en_i && !full_o;
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rd_idx_i];

  // Fill level: cleared at end of frame, bumped per accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (wr) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Storage: write lands at the current fill level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (wr) begin
      mem_q[cnt_q[IW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/alu_stream_tx.sv
// alu_stream_tx: replays buffered operand triples as one frame
// (preamble + entries), then waits for the consumer result.
module alu_stream_tx
  import alu_stream_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int GAP     = 0,
  parameter  int TIMEOUT = 64,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [OP_W-1:0]    wr_A,
  input  logic [OP_W-1:0]    wr_B,
  input  logic [INSTR_W-1:0] wr_instr,
  input  logic               start,
  output logic               buf_full,
  output logic [CW-1:0]      buf_count,
  output logic               busy,
  alu_stream_tx_if.master    s,
  output logic [OP_W-1:0]    result,
  output logic               done,
  output logic               timeout
);

  localparam int TW = $clog2(TIMEOUT + GAP + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;

  entry_t rd_data;
  logic   go, wr_ok, clr;

  logic [OP_W-1:0]    a_q, a_d;
  logic [OP_W-1:0]    b_q, b_d;
  logic [INSTR_W-1:0] ins_q, ins_d;
  logic               dv_q, dv_d;
  logic               last_q, last_d;
  logic [OP_W-1:0]    res_q, res_d;
  logic               done_q, done_d;
  logic               to_q, to_d;

  assign go    = (state_q == IDLE) && start
              && (buf_count != '0);
  assign wr_ok = (state_q == IDLE) && wr_en && !start;
  assign clr   = (state_q != IDLE) && (state_d == IDLE);

  alu_stream_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_ok),
    .wr_data_i ('{a: wr_A, b: wr_B, instr: wr_instr}),
    .clr_i     (clr),
    .rd_idx_i  (idx_d[IW-1:0]),
    .rd_data_o (rd_data),
    .count_o   (buf_count),
    .full_o    (buf_full)
  );

  // FSM state, frame length, beat index and shared cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: preamble, entries with optional gaps, result wait.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = PRE;
          n_d     = buf_count;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      PRE: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = (GAP > 0) ? GAPW : SEND;
      end
      SEND: begin
        cnt_d = '0;
        if (idx_q == n_q - CW'(1)) begin
          state_d = WAIT;
        end else begin
          idx_d   = idx_q + CW'(1);
          state_d = (GAP > 0) ? GAPW : SEND;
        end
      end
      GAPW: begin
        if (cnt_q == TW'(GAP - 1)) begin
          state_d = SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      WAIT: begin
        if (s.result_valid
            || cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next outputs from the upcoming state so beats come out registered.
  always_comb begin
    dv_d   = (state_d == PRE) || (state_d == SEND);
    a_d    = '0;
    b_d    = '0;
    ins_d  = '0;
    last_d = 1'b0;
    if (state_d == SEND) begin
      a_d    = rd_data.a;
      b_d    = rd_data.b;
      ins_d  = rd_data.instr;
      last_d = (idx_d == n_d - CW'(1));
    end
    done_d = (state_q == WAIT) && (state_d == IDLE);
    to_d   = done_d && !s.result_valid;
    res_d  = res_q;
    if (done_d && s.result_valid) begin
      res_d = s.third_largest;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      ins_q  <= '0;
      dv_q   <= 1'b0;
      last_q <= 1'b0;
      res_q  <= '0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      ins_q  <= ins_d;
      dv_q   <= dv_d;
      last_q <= last_d;
      res_q  <= res_d;
      done_q <= done_d;
      to_q   <= to_d;
    end
  end

  assign s.A          = a_q;
  assign s.B          = b_q;
  assign s.instruction = ins_q;
  assign s.data_valid = dv_q;
  assign s.last_data  = last_q;
  assign result       = res_q;
  assign done         = done_q;
  assign timeout      = to_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_stream_tx.sv
// tb_alu_stream_tx: directed frames with scoreboard queues;
// monitors pop expected beats/results as the DUTs present them.
module tb_alu_stream_tx;
  import alu_stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en [2];
  logic       st    [2];
  logic [7:0] wa    [2];
  logic [7:0] wb    [2];
  logic [3:0] wi    [2];
  logic       bfull [2];
  logic [4:0] bcnt  [2];
  logic       busy  [2];
  logic [7:0] res   [2];
  logic       done  [2];
  logic       tmo   [2];

  alu_stream_tx_if ifc0 ();
  alu_stream_tx_if ifc1 ();

  alu_stream_tx #(.DEPTH(16), .GAP(0), .TIMEOUT(64)) dut0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[0]), .wr_A(wa[0]), .wr_B(wb[0]),
    .wr_instr(wi[0]), .start(st[0]),
    .buf_full(bfull[0]), .buf_count(bcnt[0]),
    .busy(busy[0]), .s(ifc0),
    .result(res[0]), .done(done[0]), .timeout(tmo[0])
  );

  alu_stream_tx #(.DEPTH(16), .GAP(2), .TIMEOUT(64)) dut1 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[1]), .wr_A(wa[1]), .wr_B(wb[1]),
    .wr_instr(wi[1]), .start(st[1]),
    .buf_full(bfull[1]), .buf_count(bcnt[1]),
    .busy(busy[1]), .s(ifc1),
    .result(res[1]), .done(done[1]), .timeout(tmo[1])
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] i;
    logic       last;
    int         gap;
  } beat_t;

  typedef struct packed {
    logic [7:0] r;
    logic       to;
  } dn_t;

  beat_t bq0[$];
  beat_t bq1[$];
  dn_t   dq0[$];
  dn_t   dq1[$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int last_seen [2];
  int done_seen [2];
  int last_cyc  [2];
  int done_cyc  [2];
  int idle      [2];
  logic pdone   [2];

  always @(posedge clk) cyc++;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endfunction

  task automatic bad(string n);
    checks++;
    errs++;
    $display("FAIL %s", n);
  endtask

  task automatic mon_step(int d, logic dv, logic [7:0] a,
                          logic [7:0] b, logic [3:0] i,
                          logic last, logic dn, logic to,
                          logic [7:0] r);
    beat_t e;
    dn_t   x;
    int    sz;
    if (dv) begin
      sz = (d == 0) ? bq0.size() : bq1.size();
      if (sz == 0) begin
        bad($sformatf("beat%0d unexpected a=%0h b=%0h i=%0h",
                      d, a, b, i));
      end else begin
        if (d == 0) e = bq0.pop_front();
        else        e = bq1.pop_front();
        chk($sformatf("beat%0d_A", d), a, e.a);
        chk($sformatf("beat%0d_B", d), b, e.b);
        chk($sformatf("beat%0d_I", d), i, e.i);
        chk($sformatf("beat%0d_last", d), last, e.last);
        if (e.gap >= 0)
          chk($sformatf("beat%0d_gap", d), idle[d], e.gap);
      end
      idle[d] = 0;
      if (last) begin
        last_seen[d]++;
        last_cyc[d] = cyc;
      end
    end else begin
      idle[d]++;
      chk($sformatf("idle%0d_zero", d), {a, b, i, last}, 0);
    end
    if (dn) begin
      chk($sformatf("done%0d_width", d), pdone[d], 0);
      done_seen[d]++;
      done_cyc[d] = cyc;
      sz = (d == 0) ? dq0.size() : dq1.size();
      if (sz == 0) begin
        bad($sformatf("done%0d unexpected", d));
      end else begin
        if (d == 0) x = dq0.pop_front();
        else        x = dq1.pop_front();
        chk($sformatf("result%0d", d), r, x.r);
        chk($sformatf("timeout%0d", d), to, x.to);
      end
    end else begin
      chk($sformatf("timeout%0d_alone", d), to, 0);
    end
    pdone[d] = dn;
  endtask

  always @(negedge clk)
    if (rst)
      mon_step(0, ifc0.data_valid, ifc0.A, ifc0.B,
               ifc0.instruction, ifc0.last_data,
               done[0], tmo[0], res[0]);

  always @(negedge clk)
    if (rst)
      mon_step(1, ifc1.data_valid, ifc1.A, ifc1.B,
               ifc1.instruction, ifc1.last_data,
               done[1], tmo[1], res[1]);

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(int d, logic [7:0] a, logic [7:0] b,
                    logic [3:0] i);
    wr_en[d] = 1'b1;
    wa[d] = a;
    wb[d] = b;
    wi[d] = i;
    tick();
    wr_en[d] = 1'b0;
  endtask

  task automatic go(int d);
    st[d] = 1'b1;
    tick();
    st[d] = 1'b0;
  endtask

  task automatic push_b(int d, logic [7:0] a, logic [7:0] b,
                        logic [3:0] i, logic last, int gap);
    beat_t e;
    e = '{a, b, i, last, gap};
    if (d == 0) bq0.push_back(e);
    else        bq1.push_back(e);
  endtask

  task automatic push_d(int d, logic [7:0] r, logic to);
    dn_t x;
    x = '{r, to};
    if (d == 0) dq0.push_back(x);
    else        dq1.push_back(x);
  endtask

  task automatic set_rv(int d, logic v, logic [7:0] t);
    if (d == 0) begin
      ifc0.result_valid  = v;
      ifc0.third_largest = t;
    end else begin
      ifc1.result_valid  = v;
      ifc1.third_largest = t;
    end
  endtask

  task automatic respond(int d, int base, int dly,
                         logic [7:0] v);
    int n = 0;
    while (last_seen[d] == base && n < 300) begin
      tick();
      n++;
    end
    if (last_seen[d] == base) begin
      bad($sformatf("last%0d_wait expired", d));
    end else begin
      tick(dly);
      set_rv(d, 1'b1, v);
      tick();
      set_rv(d, 1'b0, 8'h00);
    end
  endtask

  task automatic wait_done(int d, int base, int bound);
    int n = 0;
    while (done_seen[d] == base && n < bound) begin
      tick();
      n++;
    end
    if (done_seen[d] == base)
      bad($sformatf("done%0d_wait expired", d));
    tick(2);
  endtask

  task automatic scen1(logic [7:0] rv);
    int lb, db;
    wr(0, 8'd5, 8'd3, 4'd0);
    wr(0, 8'd9, 8'd1, 4'd2);
    wr(0, 8'd7, 8'd7, 4'd1);
    chk("s1_count", bcnt[0], 3);
    push_b(0, 0, 0, 0, 1'b0, -1);
    push_b(0, 8'd5, 8'd3, 4'd0, 1'b0, 0);
    push_b(0, 8'd9, 8'd1, 4'd2, 1'b0, 0);
    push_b(0, 8'd7, 8'd7, 4'd1, 1'b1, 0);
    push_d(0, rv, 1'b0);
    lb = last_seen[0];
    db = done_seen[0];
    go(0);
    chk("s1_pre_latency", ifc0.data_valid, 1);
    chk("s1_busy", busy[0], 1);
    respond(0, lb, 3, rv);
    wait_done(0, db, 50);
    chk("s1_count_after", bcnt[0], 0);
    chk("s1_busy_after", busy[0], 0);
  endtask

  initial begin
    int lb, db;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 0; st[d] = 0;
      wa[d] = 0; wb[d] = 0; wi[d] = 0;
      last_seen[d] = 0; done_seen[d] = 0;
      last_cyc[d] = 0; done_cyc[d] = 0;
      idle[d] = 0; pdone[d] = 0;
    end
    set_rv(0, 1'b0, 8'h00);
    set_rv(1, 1'b0, 8'h00);
    #12;
    chk("rst_dv", ifc0.data_valid, 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_count", bcnt[0], 0);
    chk("rst_result", res[0], 0);
    chk("rst_done", done[0], 0);
    tick(2);
    rst = 1'b1;
    tick(2);

    scen1(8'h2A);

    wr(0, 8'h10, 8'h20, 4'd4);
    push_b(0, 0, 0, 0, 1'b0, -1);
    push_b(0, 8'h10, 8'h20, 4'd4, 1'b1, 0);
    push_d(0, 8'h2A, 1'b1);
    db = done_seen[0];
    go(0);
    wait_done(0, db, 200);
    chk("s3_to_latency", done_cyc[0] - last_cyc[0], 65);
    chk("s3_result_kept", res[0], 8'h2A);

    wr(1, 8'h11, 8'h22, 4'd3);
    wr(1, 8'h33, 8'h44, 4'd5);
    push_b(1, 0, 0, 0, 1'b0, -1);
    push_b(1, 8'h11, 8'h22, 4'd3, 1'b0, 2);
    push_b(1, 8'h33, 8'h44, 4'd5, 1'b1, 2);
    push_d(1, 8'h99, 1'b0);
    lb = last_seen[1];
    db = done_seen[1];
    go(1);
    respond(1, lb, 1, 8'h99);
    wait_done(1, db, 50);

    for (int k = 0; k < 16; k++)
      wr(0, 8'(k + 1), 8'(2 * k), 4'(k));
    wr(0, 8'hFF, 8'hFF, 4'hF);
    chk("s4_full", bfull[0], 1);
    chk("s4_count", bcnt[0], 16);
    push_b(0, 0, 0, 0, 1'b0, -1);
    for (int k = 0; k < 16; k++)
      push_b(0, 8'(k + 1), 8'(2 * k), 4'(k), k == 15, 0);
    push_d(0, 8'h77, 1'b0);
    lb = last_seen[0];
    db = done_seen[0];
    go(0);
    respond(0, lb, 2, 8'h77);
    wait_done(0, db, 50);
    chk("s4_full_after", bfull[0], 0);

    go(0);
    tick(3);
    chk("s5_empty_busy", busy[0], 0);
    wr(0, 8'hA1, 8'hB2, 4'd6);
    wr(0, 8'hC3, 8'hD4, 4'd7);
    push_b(0, 0, 0, 0, 1'b0, -1);
    push_b(0, 8'hA1, 8'hB2, 4'd6, 1'b0, 0);
    push_b(0, 8'hC3, 8'hD4, 4'd7, 1'b1, 0);
    push_d(0, 8'h33, 1'b0);
    lb = last_seen[0];
    db = done_seen[0];
    go(0);
    st[0] = 1'b1;
    wr(0, 8'hEE, 8'hEE, 4'hE);
    st[0] = 1'b0;
    chk("s5_count_busy", bcnt[0], 2);
    respond(0, lb, 1, 8'h33);
    wait_done(0, db, 50);
    chk("s5_count_after", bcnt[0], 0);

    for (int k = 0; k < 4; k++)
      wr(0, 8'(8'h40 + k), 8'(8'h50 + k), 4'(k + 8));
    push_b(0, 0, 0, 0, 1'b0, -1);
    for (int k = 0; k < 3; k++)
      push_b(0, 8'(8'h40 + k), 8'(8'h50 + k), 4'(k + 8),
             1'b0, 0);
    go(0);
    tick(3);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("s6_dv", ifc0.data_valid, 0);
    chk("s6_A", ifc0.A, 0);
    chk("s6_count", bcnt[0], 0);
    chk("s6_busy", busy[0], 0);
    chk("s6_done", done[0], 0);
    chk("s6_result", res[0], 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    scen1(8'h5C);

    tick(5);
    chk("bq0_empty", bq0.size(), 0);
    chk("bq1_empty", bq1.size(), 0);
    chk("dq0_empty", dq0.size(), 0);
    chk("dq1_empty", dq1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
